// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode front end: word layout, halt opcode
// and the fetch FSM state encoding.
package isa_pkg;

    localparam int unsigned INSTR_W = 12;

    localparam int unsigned OP_MSB  = 11;
    localparam int unsigned OP_LSB  = 8;
    localparam int unsigned RA_MSB  = 7;
    localparam int unsigned RA_LSB  = 4;
    localparam int unsigned IMM_MSB = 3;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_HALT
    } state_e;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// ROM request/response, branch redirect and decoded-instruction handshake bundle.
// The fetch unit is the master; ROM and execute stage sit on the slave side.
interface instr_fetch_decode_if #(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned INSTR_W = isa_pkg::INSTR_W
);
    logic               rom_req;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_valid;
    logic [INSTR_W-1:0] rom_data;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic               dec_valid;
    logic               dec_ready;
    logic [3:0]         dec_op;
    logic [3:0]         dec_ra;
    logic [3:0]         dec_imm;
    logic [ADDR_W-1:0]  dec_pc;

    modport master (
        output rom_req, rom_addr, dec_valid, dec_op, dec_ra, dec_imm, dec_pc,
        input  rom_valid, rom_data, br_taken, br_target, dec_ready
    );

    modport slave (
        input  rom_req, rom_addr, dec_valid, dec_op, dec_ra, dec_imm, dec_pc,
        output rom_valid, rom_data, br_taken, br_target, dec_ready
    );
endinterface

// File: rtl/instr_fetch_decode_pc_gen.sv
// Program counter: advances with wrap at PROG_LEN, or loads a redirect target.
// Targets outside the program fall back to address 0.
module instr_fetch_decode_pc_gen #(
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned PROG_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    // One extra bit so PROG_LEN == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   ProgLen = (ADDR_W + 1)'(PROG_LEN);
    localparam logic [ADDR_W-1:0] LastPc  = ADDR_W'(PROG_LEN - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = ({1'b0, target_i} >= ProgLen) ? '0 : target_i;
        end else if (inc_i) begin
            pc_d = (pc_q == LastPc) ? '0 : pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: walks the PC through the ROM, splits each word into
// op/ra/imm and offers it downstream on valid/ready, with branch redirect and halt.
module instr_fetch_decode #(
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned PROG_LEN = 4,
    parameter logic [3:0]  OP_HALT  = isa_pkg::OP_HALT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    instr_fetch_decode_if.master bus,
    output logic                halted
);
    import isa_pkg::*;

    state_e            state_q, state_d;
    logic              drop_q, drop_d;
    logic              dec_valid_q, dec_valid_d;
    logic [3:0]        dec_op_q, dec_op_d;
    logic [3:0]        dec_ra_q, dec_ra_d;
    logic [3:0]        dec_imm_q, dec_imm_d;
    logic [ADDR_W-1:0] dec_pc_q, dec_pc_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc, pc_load, accept, branch, halt_accept;

    assign accept      = dec_valid_q & bus.dec_ready;
    assign branch      = bus.br_taken & (state_q != S_HALT);
    assign halt_accept = (state_q == S_OUT) & accept & (dec_op_q == OP_HALT);
    // Accepting a halt beats a coincident redirect.
    assign pc_load     = branch & ~halt_accept;

    instr_fetch_decode_pc_gen #(
        .ADDR_W  (ADDR_W),
        .PROG_LEN(PROG_LEN)
    ) u_pc_gen (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (pc_inc),
        .load_i  (pc_load),
        .target_i(bus.br_target),
        .pc_o    (pc)
    );

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        dec_valid_d = dec_valid_q;
        dec_op_d    = dec_op_q;
        dec_ra_d    = dec_ra_q;
        dec_imm_d   = dec_imm_q;
        dec_pc_d    = dec_pc_q;
        rom_addr_d  = rom_addr_q;
        pc_inc      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_REQ;
            end
            S_REQ: begin
                rom_addr_d = pc;
                state_d    = S_WAIT;
                // The request is already out; its reply belongs to the old path.
                if (branch) drop_d = 1'b1;
            end
            S_WAIT: begin
                if (bus.rom_valid) begin
                    if (drop_q || branch) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        dec_op_d    = bus.rom_data[OP_MSB:OP_LSB];
                        dec_ra_d    = bus.rom_data[RA_MSB:RA_LSB];
                        dec_imm_d   = bus.rom_data[IMM_MSB:IMM_LSB];
                        dec_pc_d    = rom_addr_q;
                        dec_valid_d = 1'b1;
                        pc_inc      = 1'b1;
                        state_d     = S_OUT;
                    end
                end else if (branch) begin
                    drop_d = 1'b1;
                end
            end
            S_OUT: begin
                if (accept) begin
                    dec_valid_d = 1'b0;
                    if (dec_op_q == OP_HALT) state_d = S_HALT;
                    else if (branch || run)  state_d = S_REQ;
                    else                     state_d = S_IDLE;
                end else if (branch) begin
                    dec_valid_d = 1'b0;
                    state_d     = S_REQ;
                end
            end
            S_HALT: begin
                if (!run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drop_q      <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_op_q    <= '0;
            dec_ra_q    <= '0;
            dec_imm_q   <= '0;
            dec_pc_q    <= '0;
            rom_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            dec_valid_q <= dec_valid_d;
            dec_op_q    <= dec_op_d;
            dec_ra_q    <= dec_ra_d;
            dec_imm_q   <= dec_imm_d;
            dec_pc_q    <= dec_pc_d;
            rom_addr_q  <= rom_addr_d;
        end
    end

    assign bus.rom_req   = (state_q == S_REQ);
    assign bus.rom_addr  = (state_q == S_REQ) ? pc : rom_addr_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_op    = dec_op_q;
    assign bus.dec_ra    = dec_ra_q;
    assign bus.dec_imm   = dec_imm_q;
    assign bus.dec_pc    = dec_pc_q;
    assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a 4-word program on a PROG_LEN=4 instance
// plus a PROG_LEN=3 instance for wrap and out-of-range redirect.
module tb_instr_fetch_decode;

    logic clk = 1'b0;
    logic rst, run, run3;
    logic halted, halted3;

    always #5 clk = ~clk;

    instr_fetch_decode_if #(.ADDR_W(2)) bus ();
    instr_fetch_decode_if #(.ADDR_W(2)) bus3 ();

    instr_fetch_decode #(.ADDR_W(2), .PROG_LEN(4), .OP_HALT(4'hF)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .bus   (bus),
        .halted(halted)
    );

    instr_fetch_decode #(.ADDR_W(2), .PROG_LEN(3), .OP_HALT(4'hF)) u_dut3 (
        .clk   (clk),
        .rst   (rst),
        .run   (run3),
        .bus   (bus3),
        .halted(halted3)
    );

    logic [11:0] rom [4];
    int lat = 1, lat3 = 2;
    int checks = 0, errors = 0;
    int cyc = 0;
    int req_cnt = 0;
    int q_pc[$], q_op[$], q_ra[$], q_imm[$], q_cyc[$];
    int q3_pc[$], q3_op[$];
    int rom_cnt = 0, rom3_cnt = 0;
    logic [1:0] rom_a = '0, rom3_a = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted-instruction and request monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.dec_valid && bus.dec_ready) begin
                q_pc.push_back(int'(bus.dec_pc));
                q_op.push_back(int'(bus.dec_op));
                q_ra.push_back(int'(bus.dec_ra));
                q_imm.push_back(int'(bus.dec_imm));
                q_cyc.push_back(cyc);
            end
            if (bus.rom_req) req_cnt++;
            if (bus3.dec_valid && bus3.dec_ready) begin
                q3_pc.push_back(int'(bus3.dec_pc));
                q3_op.push_back(int'(bus3.dec_op));
            end
        end
    end

    // ROM models: rom_valid for one cycle, `lat` cycles after the request cycle.
    initial begin
        bus.rom_valid = 1'b0;
        bus.rom_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.rom_req) begin
                rom_cnt = lat;
                rom_a = bus.rom_addr;
                bus.rom_valid = 1'b0;
            end else if (rom_cnt > 0) begin
                rom_cnt--;
                bus.rom_valid = (rom_cnt == 0);
                bus.rom_data  = rom[rom_a];
            end else begin
                bus.rom_valid = 1'b0;
            end
        end
    end

    initial begin
        bus3.rom_valid = 1'b0;
        bus3.rom_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (bus3.rom_req) begin
                rom3_cnt = lat3;
                rom3_a = bus3.rom_addr;
                bus3.rom_valid = 1'b0;
            end else if (rom3_cnt > 0) begin
                rom3_cnt--;
                bus3.rom_valid = (rom3_cnt == 0);
                bus3.rom_data  = rom[rom3_a];
            end else begin
                bus3.rom_valid = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        run3 = 1'b0;
        bus.dec_ready = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        bus3.dec_ready = 1'b0;
        bus3.br_taken = 1'b0;
        bus3.br_target = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_pc.delete(); q_op.delete(); q_ra.delete(); q_imm.delete(); q_cyc.delete();
        q3_pc.delete(); q3_op.delete();
    endtask

    task automatic wait_acc(input int n, input int budget, input bit on3, output bit ok);
        int k = 0;
        while (((on3 ? q3_pc.size() : q_pc.size()) < n) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        ok = ((on3 ? q3_pc.size() : q_pc.size()) >= n);
    endtask

    task automatic wait_req(input int addr, input int budget, input bit on3, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (!ok && k < budget) begin
            @(posedge clk); #1;
            if (on3) ok = bus3.rom_req && (int'(bus3.rom_addr) == addr);
            else     ok = bus.rom_req && (int'(bus.rom_addr) == addr);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        run3 = 1'b0;
        #1;
        checks++;
        if (bus.rom_req !== 1'b0 || bus.rom_addr !== 2'd0) begin
            errors++;
            $display("FAIL reset_rom: req=%b addr=%0d, want 0/0", bus.rom_req, bus.rom_addr);
        end
        checks++;
        if (bus.dec_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: dec_valid=%b halted=%b, want 0/0", bus.dec_valid, halted);
        end
        checks++;
        if ({bus.dec_op, bus.dec_ra, bus.dec_imm} !== 12'h000) begin
            errors++;
            $display("FAIL reset_fields: %h, want 000", {bus.dec_op, bus.dec_ra, bus.dec_imm});
        end
        checks++;
        if (bus.dec_pc !== 2'd0) begin
            errors++;
            $display("FAIL reset_dec_pc: %0d, want 0", bus.dec_pc);
        end
    endtask

    task automatic test_stream();
        int exp_pc[5] = '{0, 1, 2, 3, 0};
        int exp_op[5] = '{1, 4, 7, 10, 1};
        bit ok;
        do_reset();
        run = 1'b1;
        bus.dec_ready = 1'b1;
        wait_acc(5, 40, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_timeout: got %0d accepts, want 5", q_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_pc[i] != exp_pc[i] || q_op[i] != exp_op[i]) begin
                    errors++;
                    $display("FAIL stream_word%0d: pc=%0d op=%h, want pc=%0d op=%h",
                             i, q_pc[i], q_op[i], exp_pc[i], exp_op[i]);
                end
            end
            checks++;
            if (q_ra[2] != 8 || q_imm[2] != 9) begin
                errors++;
                $display("FAIL stream_fields: ra=%h imm=%h, want 8/9", q_ra[2], q_imm[2]);
            end
            checks++;
            if (q_cyc[1] - q_cyc[0] != 3 || q_cyc[4] - q_cyc[3] != 3) begin
                errors++;
                $display("FAIL back_to_back: gaps %0d,%0d, want 3,3",
                         q_cyc[1] - q_cyc[0], q_cyc[4] - q_cyc[3]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int k = 0;
        int r0;
        int moved = 0;
        logic [3:0] s_op, s_ra, s_imm;
        logic [1:0] s_pc;
        do_reset();
        run = 1'b1;
        bus.dec_ready = 1'b1;
        wait_acc(1, 20, 1'b0, ok);
        bus.dec_ready = 1'b0;
        while (!bus.dec_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        s_op = bus.dec_op; s_ra = bus.dec_ra; s_imm = bus.dec_imm; s_pc = bus.dec_pc;
        r0 = req_cnt;
        checks++;
        if (!ok || bus.dec_valid !== 1'b1 || {s_op, s_ra, s_imm} !== 12'h456 || s_pc !== 2'd1)
        begin
            errors++;
            $display("FAIL stall_word: valid=%b word=%h pc=%0d, want 1/456/1",
                     bus.dec_valid, {s_op, s_ra, s_imm}, s_pc);
        end
        repeat (5) begin
            @(negedge clk);
            if (bus.dec_valid !== 1'b1 || bus.dec_op !== s_op || bus.dec_ra !== s_ra ||
                bus.dec_imm !== s_imm || bus.dec_pc !== s_pc) moved++;
        end
        checks++;
        if (moved != 0) begin
            errors++;
            $display("FAIL stall_stable: %0d unstable cycles, want 0", moved);
        end
        @(posedge clk); #1;
        checks++;
        if (req_cnt != r0) begin
            errors++;
            $display("FAIL stall_no_req: %0d requests during stall, want 0", req_cnt - r0);
        end
        bus.dec_ready = 1'b1;
        wait_acc(2, 10, 1'b0, ok);
        checks++;
        if (!ok || q_pc[1] != 1 || q_op[1] != 4) begin
            errors++;
            $display("FAIL stall_accept: ok=%b pc=%0d op=%h, want 1/1/4",
                     ok, ok ? q_pc[1] : -1, ok ? q_op[1] : -1);
        end
    endtask

    task automatic test_branch();
        bit ok;
        lat = 2;
        do_reset();
        run = 1'b1;
        bus.dec_ready = 1'b1;
        wait_req(1, 30, 1'b0, ok);
        @(posedge clk); #1;
        bus.br_taken = 1'b1;
        bus.br_target = 2'd3;
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
        bus.br_target = 2'd0;
        if (ok) wait_acc(3, 40, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL branch_timeout: got %0d accepts, want 3", q_pc.size());
        end else begin
            checks++;
            if (q_pc[1] != 3 || q_op[1] != 10) begin
                errors++;
                $display("FAIL branch_target: pc=%0d op=%h, want 3/a", q_pc[1], q_op[1]);
            end
            checks++;
            if (q_op[0] == 4 || q_op[2] == 4 || q_pc[2] != 0) begin
                errors++;
                $display("FAIL branch_drop: ops %h,%h pc2=%0d, want no 4 and pc2=0",
                         q_op[0], q_op[2], q_pc[2]);
            end
        end
        lat = 1;
    endtask

    task automatic test_halt();
        bit ok;
        int r0;
        rom[2] = 12'hF00;
        do_reset();
        run = 1'b1;
        bus.dec_ready = 1'b1;
        wait_acc(3, 30, 1'b0, ok);
        checks++;
        if (!ok || q_op[2] != 15 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_enter: ok=%b halted=%b, want 1/1", ok, halted);
        end
        r0 = req_cnt;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (req_cnt != r0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold: reqs=%0d halted=%b, want 0/1", req_cnt - r0, halted);
        end
        run = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_release: halted=%b, want 0", halted);
        end
        run = 1'b1;
        wait_acc(4, 20, 1'b0, ok);
        checks++;
        if (!ok || q_pc[3] != 3 || q_op[3] != 10) begin
            errors++;
            $display("FAIL halt_resume: ok=%b pc=%0d, want 1/3", ok, ok ? q_pc[3] : -1);
        end
        rom[2] = 12'h789;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0, n0;
        lat = 3;
        do_reset();
        run = 1'b1;
        bus.dec_ready = 1'b1;
        wait_req(1, 30, 1'b0, ok);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (!ok || bus.rom_addr !== 2'd0 || bus.rom_req !== 1'b0 || bus.dec_pc !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_addr: ok=%b addr=%0d req=%b dec_pc=%0d, want 1/0/0/0",
                     ok, bus.rom_addr, bus.rom_req, bus.dec_pc);
        end
        checks++;
        if ({bus.dec_op, bus.dec_ra, bus.dec_imm} !== 12'h000 || bus.dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fields: word=%h valid=%b, want 000/0",
                     {bus.dec_op, bus.dec_ra, bus.dec_imm}, bus.dec_valid);
        end
        run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        r0 = req_cnt;
        n0 = q_pc.size();
        repeat (6) begin
            @(posedge clk); #1;
        end
        checks++;
        if (q_pc.size() != n0 || req_cnt != r0 || bus.dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late: accepts=%0d reqs=%0d valid=%b, want 0/0/0",
                     q_pc.size() - n0, req_cnt - r0, bus.dec_valid);
        end
        run = 1'b1;
        wait_acc(n0 + 1, 20, 1'b0, ok);
        checks++;
        if (!ok || q_pc[n0] != 0 || q_op[n0] != 1) begin
            errors++;
            $display("FAIL rst_mid_restart: ok=%b pc=%0d, want 1/0", ok, ok ? q_pc[n0] : -1);
        end
        lat = 1;
    endtask

    task automatic test_prog_len3();
        bit ok;
        int n;
        do_reset();
        run3 = 1'b1;
        bus3.dec_ready = 1'b1;
        wait_acc(4, 60, 1'b1, ok);
        checks++;
        if (!ok || q3_pc[0] != 0 || q3_pc[1] != 1 || q3_pc[2] != 2 || q3_pc[3] != 0) begin
            errors++;
            $display("FAIL len3_wrap: ok=%b accepts=%0d, want pcs 0,1,2,0", ok, q3_pc.size());
        end
        wait_req(1, 30, 1'b1, ok);
        @(posedge clk); #1;
        bus3.br_taken = 1'b1;
        bus3.br_target = 2'd3;
        @(posedge clk); #1;
        bus3.br_taken = 1'b0;
        n = q3_pc.size();
        if (ok) wait_acc(n + 1, 30, 1'b1, ok);
        checks++;
        if (!ok || q3_pc[n] != 0 || q3_op[n] != 1) begin
            errors++;
            $display("FAIL len3_branch: ok=%b pc=%0d, want 1/0", ok, ok ? q3_pc[n] : -1);
        end
    endtask

    initial begin
        rom[0] = 12'h123;
        rom[1] = 12'h456;
        rom[2] = 12'h789;
        rom[3] = 12'hABC;
        bus.dec_ready = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        bus3.dec_ready = 1'b0;
        bus3.br_taken = 1'b0;
        bus3.br_target = '0;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_halt();
        test_reset_mid();
        test_prog_len3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
